// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with a final sign-fix cycle before HI/LO are written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]   ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [WIDTH-1:0]     r_opb;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [CW-1:0]        r_cnt;

  logic                 w_signed;
  logic                 w_dbz;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH-1:0]     w_mul_add;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;

  assign w_signed  = ~op[0];
  assign w_dbz     = op[1] & (B == {WIDTH{1'b0}});
  assign w_mag_a   = (w_signed & A[WIDTH-1]) ? neg_w(A) : A;
  assign w_mag_b   = (w_signed & B[WIDTH-1]) ? neg_w(B) : B;
  assign w_mul_add = r_acc[0] ? r_opb : {WIDTH{1'b0}};
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_add};
  // Remainder stays below the divisor, so the top bit of the difference is the borrow.
  assign w_shift   = {r_rem, r_acc[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opb};
  assign w_ge      = ~w_diff[WIDTH];

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = w_dbz ? S_DONE : S_RUN;
        else       w_next_state = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) w_next_state = S_FIX;
        else                   w_next_state = S_RUN;
      end
      S_FIX:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy        <= (w_next_state == S_RUN) | (w_next_state == S_FIX);
      done        <= (w_next_state == S_DONE);
      div_by_zero <= (r_state == S_IDLE) & start & w_dbz;
    end
  end

  // For multiply r_opb is the multiplicand; for divide it is the divisor.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opb     <= {WIDTH{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_rem     <= {WIDTH{1'b0}};
      r_cnt     <= {CW{1'b0}};
      HI        <= {WIDTH{1'b0}};
      LO        <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div  <= op[1];
            r_neg_res <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_rem <= w_signed & A[WIDTH-1];
            r_rem     <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            if (op[1]) begin
              r_opb <= w_mag_b;
              r_acc <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_opb <= w_mag_a;
              r_acc <= {{WIDTH{1'b0}}, w_mag_b};
            end
            if (w_dbz) begin
              HI <= A;
              LO <= {WIDTH{1'b1}};
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_is_div) begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            LO <= r_neg_res ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
            HI <= r_neg_rem ? neg_w(r_rem) : r_rem;
          end else begin
            {HI, LO} <= r_neg_res ? neg_2w(r_acc) : r_acc;
          end
        end
        S_DONE: begin
          r_cnt <= {CW{1'b0}};
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_mult_div_unit;

  logic        Clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = 32'd0;
    lo  = 32'd0;
    case (o)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dbz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at);
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          n;
    int          busy_n;
    ref_model(o, a, b, ehi, elo, edbz);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
    n = 0; busy_n = 0;
    while (!done && n < 60) begin
      if (busy) busy_n++;
      if (n == poke_at) begin
        start = 1'b1; A = $urandom; B = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge Clk); #1;
      n++;
    end
    start = 1'b0;
    check_eq("latency", n, edbz ? 0 : 33);
    check_eq("busy_cycles", busy_n, edbz ? 0 : 33);
    check_eq("done", done, 1'b1);
    check_eq("div_by_zero", div_by_zero, edbz);
    check_eq("busy_at_done", busy, 1'b0);
    check_eq("HI", HI, ehi);
    check_eq("LO", LO, elo);
    // A start presented while in DONE must be dropped.
    start = 1'b1; op = 2'($urandom); A = $urandom; B = $urandom_range(0, 1);
    @(posedge Clk); #1;
    start = 1'b0;
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("start_in_done_ignored", busy, 1'b0);
    check_eq("dbz_one_cycle", div_by_zero, 1'b0);
    check_eq("HI_hold", HI, ehi);
    check_eq("LO_hold", LO, elo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_dbz", div_by_zero, 1'b0);
    check_eq("rst_HI", HI, 32'd0);
    check_eq("rst_LO", LO, 32'd0);
    repeat (2) @(posedge Clk);
    #1 reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1);
    check_eq("mult_neg3x7", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check_eq("mult_m1xm1", {HI, LO}, 64'h0000_0000_0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    check_eq("div_neg7by2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7, -1);
    check_eq("divu_100by7", {HI, LO}, 64'h0000_0002_0000_000E);
    run_op(2'b11, 32'h1234_5678, 32'd0, -1);
    check_eq("divu_by_zero", {HI, LO}, 64'h1234_5678_FFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check_eq("div_min_by_m1", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op(2'b00, 32'd5, 32'd6, 10);
    check_eq("mult_5x6_poked", {HI, LO}, 64'd30);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      if (ro[1] && $urandom_range(0, 7) == 0) rb = 32'd0;
      run_op(ro, ra, rb, (i % 4 == 0) ? int'($urandom_range(0, 31)) : -1);
    end

    run_op(2'b11, 32'd100, 32'd7, -1);
    op = 2'b11; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (14) @(posedge Clk);
    #1 reset = 1'b1;
    #1;
    check_eq("midop_rst_busy", busy, 1'b0);
    check_eq("midop_rst_done", done, 1'b0);
    check_eq("midop_rst_HI", HI, 32'd0);
    check_eq("midop_rst_LO", LO, 32'd0);
    @(posedge Clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (done || busy || div_by_zero) seen++;
    end
    check_eq("no_activity_after_rst", seen, 0);
    check_eq("HI_still_zero", HI, 32'd0);
    run_op(2'b01, 32'd3, 32'd4, -1);
    check_eq("multu_3x4", {HI, LO}, 64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
